score_scan_driver: RTL and testbench



---
 rtl/score_pkg.sv | 35 +++
 rtl/bcd_score_counter.sv | 51 +++++
 rtl/score_scan_driver.sv | 92 +++++++++
 tb/tb_score_scan_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants and types for the scoreboard scan path.
// Digit slots, anode patterns and the BCD score type.
package score_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [1:0] DIG_P1_TENS = 2'd3;
  localparam logic [1:0] DIG_P1_ONES = 2'd2;
  localparam logic [1:0] DIG_P2_TENS = 2'd1;
  localparam logic [1:0] DIG_P2_ONES = 2'd0;

  localparam logic [3:0] AN_P1_TENS = 4'b0111;
  localparam logic [3:0] AN_P1_ONES = 4'b1011;
  localparam logic [3:0] AN_P2_TENS = 4'b1101;
  localparam logic [3:0] AN_P2_ONES = 4'b1110;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_score_t;

  function automatic bcd_score_t to_bcd(input int unsigned v);
    bcd_score_t s;
    s.tens = 4'((v / 10) % 10);
    s.ones = 4'(v % 10);
    return s;
  endfunction

  // Leading-zero suppression for tens digits.
  function automatic logic [3:0] blank_zero(input logic [3:0] d);
    return (d == 4'd0) ? BLANK_CODE : d;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score with saturation at 99.
// Flags a win when an increment lands on WIN_SCORE.
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clr,
  input  logic       inc,
  input  logic       en,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       hit_win
);

  localparam bcd_score_t WIN_BCD = to_bcd(WIN_SCORE);

  bcd_score_t q;
  bcd_score_t nxt;
  logic       step;

  assign step = inc & en & ~clr;

  always_comb begin
    nxt = q;
    if (q.ones != 4'd9) begin
      nxt.ones = q.ones + 4'd1;
    end else if (q.tens != 4'd9) begin
      nxt.ones = 4'd0;
      nxt.tens = q.tens + 4'd1;
    end
  end

  assign hit_win = step & (nxt == WIN_BCD);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (step) begin
      q <= nxt;
    end
  end

  assign tens = q.tens;
  assign ones = q.ones;

endmodule

// File: rtl/score_scan_driver.sv
// Score keeping and digit scan for the Pong scoreboard.
// AN lags count by one cycle to line up with the decoder register.
module score_scan_driver
  import score_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned WIN_SCORE    = 11
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       GAME_CLR,
  input  logic       P1_POINT,
  input  logic       P2_POINT,
  output logic [3:0] count,
  output logic [3:0] AN,
  output logic       GAME_OVER,
  output logic [1:0] WINNER
);

  logic [REFRESH_BITS-1:0] scan;
  logic [1:0] idx;
  logic [3:0] p1_tens, p1_ones;
  logic [3:0] p2_tens, p2_ones;
  logic       p1_hit, p2_hit;
  logic [3:0] digit, an_sel, an_q;

  assign idx = scan[REFRESH_BITS-1 -: 2];

  bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p1 (
    .CLK(CLK), .RST_N(RST_N),
    .clr(GAME_CLR), .inc(P1_POINT), .en(~GAME_OVER),
    .tens(p1_tens), .ones(p1_ones), .hit_win(p1_hit)
  );

  bcd_score_counter #(.WIN_SCORE(WIN_SCORE)) u_p2 (
    .CLK(CLK), .RST_N(RST_N),
    .clr(GAME_CLR), .inc(P2_POINT), .en(~GAME_OVER),
    .tens(p2_tens), .ones(p2_ones), .hit_win(p2_hit)
  );

  always_comb begin
    digit  = BLANK_CODE;
    an_sel = AN_OFF;
    unique case (1'b1)
      (idx == DIG_P1_TENS): begin
        digit  = blank_zero(p1_tens);
        an_sel = AN_P1_TENS;
      end
      (idx == DIG_P1_ONES): begin
        digit  = p1_ones;
        an_sel = AN_P1_ONES;
      end
      (idx == DIG_P2_TENS): begin
        digit  = blank_zero(p2_tens);
        an_sel = AN_P2_TENS;
      end
      (idx == DIG_P2_ONES): begin
        digit  = p2_ones;
        an_sel = AN_P2_ONES;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan  <= '0;
      count <= BLANK_CODE;
      an_q  <= AN_OFF;
      AN    <= AN_OFF;
    end else begin
      scan  <= scan + 1'b1;
      count <= digit;
      an_q  <= an_sel;
      AN    <= an_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      GAME_OVER <= 1'b0;
      WINNER    <= 2'b00;
    end else if (GAME_CLR) begin
      GAME_OVER <= 1'b0;
      WINNER    <= 2'b00;
    end else if (p1_hit | p2_hit) begin
      GAME_OVER <= 1'b1;
      WINNER    <= WINNER | {p1_hit, p2_hit};
    end
  end

endmodule

// File: tb/tb_score_scan_driver.sv
// Bench for score_scan_driver: two instances (win at 11 and 99)
// checked every cycle against an integer score model.
module tb_score_scan_driver;

  localparam int RB = 4;

  logic CLK = 1'b0;
  logic RST_N, GAME_CLR, P1_POINT, P2_POINT;
  logic [3:0] count_a, AN_a, count_b, AN_b;
  logic GAME_OVER_a, GAME_OVER_b;
  logic [1:0] WINNER_a, WINNER_b;

  score_scan_driver #(.REFRESH_BITS(RB), .WIN_SCORE(11)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .GAME_CLR(GAME_CLR),
    .P1_POINT(P1_POINT), .P2_POINT(P2_POINT),
    .count(count_a), .AN(AN_a),
    .GAME_OVER(GAME_OVER_a), .WINNER(WINNER_a)
  );

  score_scan_driver #(.REFRESH_BITS(RB), .WIN_SCORE(99)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .GAME_CLR(GAME_CLR),
    .P1_POINT(P1_POINT), .P2_POINT(P2_POINT),
    .count(count_b), .AN(AN_b),
    .GAME_OVER(GAME_OVER_b), .WINNER(WINNER_b)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  int win_s[2];
  int sc1[2];
  int sc2[2];
  bit go[2];
  logic [1:0] wn[2];
  int ncyc;

  typedef struct {
    bit p1;
    bit p2;
    bit clr;
    bit go;
    logic [1:0] win;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic int idx_of(input int n);
    return (n >> (RB - 2)) % 4;
  endfunction

  function automatic logic [3:0] exp_digit(input int k, input int i);
    int s;
    s = (i >= 2) ? sc1[k] : sc2[k];
    if (i % 2 == 1) return (s / 10 == 0) ? 4'hF : 4'(s / 10);
    return 4'(s % 10);
  endfunction

  task automatic model_reset();
    ncyc = 0;
    for (int k = 0; k < 2; k++) begin
      sc1[k] = 0; sc2[k] = 0; go[k] = 0; wn[k] = 2'b00;
    end
  endtask

  task automatic step(input bit a, input bit b, input bit c);
    logic [3:0] ec[2];
    logic [3:0] ea;
    bit h1, h2;
    P1_POINT = a; P2_POINT = b; GAME_CLR = c;
    @(posedge CLK);
    for (int k = 0; k < 2; k++) ec[k] = exp_digit(k, idx_of(ncyc));
    ea = (ncyc >= 1) ? ~(4'b0001 << idx_of(ncyc - 1)) : 4'hF;
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        sc1[k] = 0; sc2[k] = 0; go[k] = 0; wn[k] = 2'b00;
      end else if (!go[k]) begin
        h1 = 0; h2 = 0;
        if (a) begin
          if (sc1[k] < 99) sc1[k]++;
          h1 = (sc1[k] == win_s[k]);
        end
        if (b) begin
          if (sc2[k] < 99) sc2[k]++;
          h2 = (sc2[k] == win_s[k]);
        end
        if (h1 || h2) begin
          go[k] = 1;
          wn[k] = wn[k] | {h1, h2};
        end
      end
    end
    ncyc++;
    #1;
    chk("count_a", count_a, ec[0]);
    chk("count_b", count_b, ec[1]);
    chk("an_a", AN_a, ea);
    chk("an_b", AN_b, ea);
    chk("game_over_a", GAME_OVER_a, go[0]);
    chk("game_over_b", GAME_OVER_b, go[1]);
    chk("winner_a", WINNER_a, wn[0]);
    chk("winner_b", WINNER_b, wn[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic push(input bit a, input bit b, input bit c,
                      input bit g, input logic [1:0] w);
    vec_t v;
    v.p1 = a; v.p2 = b; v.clr = c; v.go = g; v.win = w;
    tbl.push_back(v);
    v.p1 = 0; v.p2 = 0; v.clr = 0;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    win_s[0] = 11;
    win_s[1] = 99;
    model_reset();
    GAME_CLR = 0; P1_POINT = 0; P2_POINT = 0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #10;
    chk("rst_count", count_a, 4'hF);
    chk("rst_an", AN_a, 4'hF);
    chk("rst_game_over", GAME_OVER_a, 1'b0);
    chk("rst_winner", WINNER_a, 2'b00);
    #1 RST_N = 1'b1;

    idle(64);

    for (int i = 1; i <= 10; i++) push(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 10; i++) push(0, 0, 0, 0, 2'b00);
    push(1, 0, 0, 1, 2'b10);
    push(1, 0, 0, 1, 2'b10);
    push(0, 0, 1, 0, 2'b00);
    for (int i = 1; i <= 10; i++) push(1, 1, 0, 0, 2'b00);
    push(1, 1, 0, 1, 2'b11);
    push(0, 0, 1, 0, 2'b00);
    for (int i = 1; i <= 5; i++) push(0, 1, 0, 0, 2'b00);
    push(0, 1, 1, 0, 2'b00);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].p1, tbl[i].p2, tbl[i].clr);
      chk("tbl_game_over", GAME_OVER_a, tbl[i].go);
      chk("tbl_winner", WINNER_a, tbl[i].win);
    end
    idle(20);

    step(0, 0, 1);
    for (int i = 1; i <= 100; i++) step(1, 0, 0);
    idle(20);
    chk("win99_game_over", GAME_OVER_b, 1'b1);
    chk("win99_winner", WINNER_b, 2'b10);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0);

    step(0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    idle(3);
    #1 RST_N = 1'b0;
    #1;
    chk("async_count_a", count_a, 4'hF);
    chk("async_count_b", count_b, 4'hF);
    chk("async_an_a", AN_a, 4'hF);
    chk("async_an_b", AN_b, 4'hF);
    chk("async_game_over", GAME_OVER_a, 1'b0);
    #2 RST_N = 1'b1;
    model_reset();
    idle(24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
